bit_serializer: RTL

- Parallel-in, serial-out feeder that sits directly upstream of the bit-stream sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on x, which drives the detector's x input.
- When no word is available, x holds a configurable idle level. The detector samples every clock, so x always carries a defined value.

---
 rtl/bit_serializer_pkg.sv | 13 +
 rtl/bit_serializer_ser_shift_reg.sv | 52 +++++
 rtl/bit_serializer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit_serializer slice: FSM state encoding and the
// word counter width (matched to the downstream sequence detectors).
package bit_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      PARITY = 2'b10
   } state_e;

   localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/bit_serializer_ser_shift_reg.sv
// ser_shift_reg: shift/bit-count datapath for bit_serializer.
// Holds the word in flight, counts presented bits and flags the last one.
// nxt_bit_o is the bit that will be at the front after this edge, so the top
// can register x without an extra pipeline stage.
module ser_shift_reg #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             nxt_bit_o,
   output logic             last_o
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Next shift-register contents and bit count
   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         sreg_d = din_i;
         cnt_d  = '0;
      end else if (shift_i) begin
         if (MSB_FIRST != 0) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
         else                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
         cnt_d = cnt_q + CW'(1);
      end
      nxt_bit_o = (MSB_FIRST != 0) ? sreg_d[WIDTH-1] : sreg_d[0];
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

   assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-in, serial-out feeder for the sequence detectors.
// Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit
// per clock on a registered x, holding IDLE_BIT when no word is in flight.
// Optional macro BIT_SERIALIZER_PARITY_EN appends an even-parity bit per word.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 1,
   parameter logic        IDLE_BIT  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic [CNT_W-1:0] words_sent
);

   state_e           state_q, state_d;
   logic             x_q, x_d;
   logic             xv_q, xv_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic             load, shift, nxt_bit, last;
`ifdef BIT_SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   ser_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .shift_i   (shift),
      .din_i     (din),
      .nxt_bit_o (nxt_bit),
      .last_o    (last)
   );

   // Next-state, handshake and word counting; din_ready never looks at din_valid
   always_comb begin
      state_d   = state_q;
      words_d   = words_q;
      load      = 1'b0;
      shift     = 1'b0;
      din_ready = 1'b0;
      case (state_q)
         IDLE: begin
            din_ready = 1'b1;
            if (din_valid) begin
               load    = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!last) begin
               shift = 1'b1;
            end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
               state_d = PARITY;
`else
               din_ready = 1'b1;
               words_d   = words_q + CNT_W'(1);
               load      = din_valid;
               state_d   = din_valid ? SHIFT : IDLE;
`endif
            end
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         PARITY: begin
            din_ready = 1'b1;
            words_d   = words_q + CNT_W'(1);
            load      = din_valid;
            state_d   = din_valid ? SHIFT : IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Registered serial output follows the state being entered
   always_comb begin
      xv_d = (state_d != IDLE);
      case (state_d)
         SHIFT:   x_d = nxt_bit;
`ifdef BIT_SERIALIZER_PARITY_EN
         PARITY:  x_d = par_q;
`endif
         default: x_d = IDLE_BIT;
      endcase
`ifdef BIT_SERIALIZER_PARITY_EN
      par_d = load ? ^din : par_q;
`endif
   end

   // State, output and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= IDLE_BIT;
         xv_q    <= 1'b0;
         words_q <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         xv_q    <= xv_d;
         words_q <= words_d;
`ifdef BIT_SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign x          = x_q;
   assign x_valid    = xv_q;
   assign busy       = (state_q != IDLE);
   assign words_sent = words_q;

endmodule
